// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared pc_select / branch_cond encodings,
// default reset PC and step, and the branch-condition evaluator.
package pc_seq_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0;
  localparam int DEF_PC_STEP = 4;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'b000,
    SEL_BR   = 3'b001,
    SEL_JMP  = 3'b010,
    SEL_JR   = 3'b011,
    SEL_CALL = 3'b100,
    SEL_RET  = 3'b101
  } pc_sel_e;

  typedef enum logic [2:0] {
    BC_EQ  = 3'b000,
    BC_NE  = 3'b001,
    BC_LT  = 3'b010,
    BC_GE  = 3'b011,
    BC_LTU = 3'b100,
    BC_GEU = 3'b101
  } br_cond_e;

  function automatic logic br_eval(
    input logic [2:0] c,
    input logic       z,
    input logic       n,
    input logic       v,
    input logic       cy
  );
    logic r;
    r = 1'b0;
    case (c)
      BC_EQ:   r = z;
      BC_NE:   r = !z;
      BC_LT:   r = n ^ v;
      BC_GE:   r = !(n ^ v);
      BC_LTU:  r = !cy;
      BC_GEU:  r = cy;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/target inputs and PC/stack status outputs.
// master drives select, flags and targets; slave (the sequencer) drives PC and status.
interface pc_sequencer_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int SIGNAL_WIDTH = 3
);
  logic                    stall;
  logic [SIGNAL_WIDTH-1:0] pc_select;
  logic [2:0]              branch_cond;
  logic                    zero;
  logic                    negative;
  logic                    overflow;
  logic                    carry;
  logic [DATA_WIDTH-1:0]   ext_sum;
  logic [DATA_WIDTH-1:0]   ext_signal;
  logic [DATA_WIDTH-1:0]   reg_bank_upper_data;
  logic [DATA_WIDTH-1:0]   pc_out;
  logic [DATA_WIDTH-1:0]   pc_plus;
  logic                    branch_taken;
  logic                    ras_empty;
  logic                    ras_full;
  logic                    ras_error;

  modport master (
    output stall, pc_select, branch_cond,
    output zero, negative, overflow, carry,
    output ext_sum, ext_signal, reg_bank_upper_data,
    input  pc_out, pc_plus, branch_taken,
    input  ras_empty, ras_full, ras_error
  );

  modport slave (
    input  stall, pc_select, branch_cond,
    input  zero, negative, overflow, carry,
    input  ext_sum, ext_signal, reg_bank_upper_data,
    output pc_out, pc_plus, branch_taken,
    output ras_empty, ras_full, ras_error
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: circular return-address stack; a push when full overwrites
// the oldest entry. Only built when PC_SEQUENCER_RAS_EN is defined.
`ifdef PC_SEQUENCER_RAS_EN
module return_stack #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_empty,
  output logic          o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_top;

  assign w_top   = r_ptr - PW'(1);
  assign o_data  = r_mem[w_top];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!o_full) r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr <= w_top;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // storage needs no reset: the count gates every read
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_ptr] <= i_data;
  end
endmodule
`endif

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC with branch/jump/call/return selection.
// Ports: clk, rst_n, bus (pc_sequencer_if.slave). Macro PC_SEQUENCER_RAS_EN adds the return stack.
import pc_seq_pkg::*;

module pc_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int SIGNAL_WIDTH = 3,
  parameter int RAS_DEPTH    = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(DEF_RESET_PC),
  parameter int PC_STEP      = DEF_PC_STEP
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_plus;
  logic [DATA_WIDTH-1:0] w_next;
  logic                  r_bt;
  logic                  w_bt;
  logic                  w_cond;
  logic                  w_is_br;
  logic                  w_is_jmp;
  logic                  w_is_jr;
  logic                  w_is_call;
  logic                  w_is_ret;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_err;

  assign w_plus    = r_pc + DATA_WIDTH'(PC_STEP);
  assign w_is_br   = bus.pc_select == SIGNAL_WIDTH'(SEL_BR);
  assign w_is_jmp  = bus.pc_select == SIGNAL_WIDTH'(SEL_JMP);
  assign w_is_jr   = bus.pc_select == SIGNAL_WIDTH'(SEL_JR);
  assign w_is_call = bus.pc_select == SIGNAL_WIDTH'(SEL_CALL);
  assign w_is_ret  = bus.pc_select == SIGNAL_WIDTH'(SEL_RET);
  assign w_cond    = br_eval(bus.branch_cond, bus.zero,
                             bus.negative, bus.overflow, bus.carry);

`ifdef PC_SEQUENCER_RAS_EN
  logic [DATA_WIDTH-1:0] w_top;
  logic                  w_push;
  logic                  w_pop;
  logic                  r_err;

  assign w_push = !bus.stall && w_is_call;
  assign w_pop  = !bus.stall && w_is_ret;
  assign w_err  = r_err;

  return_stack #(
    .DW    (DATA_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_plus),
    .o_data  (w_top),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_err <= 1'b0;
    else if (w_pop && w_empty) r_err <= 1'b1;
  end
`else
  assign w_empty = 1'b1;
  assign w_full  = 1'b0;
  assign w_err   = 1'b0;
`endif

  always_comb begin
    w_next = w_plus;
    w_bt   = 1'b0;
    unique case (1'b1)
      w_is_br: begin
        if (w_cond) begin
          w_next = bus.ext_sum;
          w_bt   = 1'b1;
        end
      end
      w_is_jmp, w_is_call: begin
        w_next = bus.ext_signal;
        w_bt   = 1'b1;
      end
      w_is_jr: begin
        w_next = bus.reg_bank_upper_data;
        w_bt   = 1'b1;
      end
      w_is_ret: begin
`ifdef PC_SEQUENCER_RAS_EN
        // empty stack: fall through sequentially
        if (!w_empty) begin
          w_next = w_top;
          w_bt   = 1'b1;
        end
`else
        w_next = bus.reg_bank_upper_data;
        w_bt   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
      r_bt <= 1'b0;
    end else if (!bus.stall) begin
      r_pc <= w_next;
      r_bt <= w_bt;
    end
  end

  assign bus.pc_out       = r_pc;
  assign bus.pc_plus      = w_plus;
  assign bus.branch_taken = r_bt;
  assign bus.ras_empty    = w_empty;
  assign bus.ras_full     = w_full;
  assign bus.ras_error    = w_err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer
// against a queue-based reference model.
module tb_pc_sequencer;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h100;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;

  pc_sequencer_if #(.DATA_WIDTH(32), .SIGNAL_WIDTH(3)) bus ();

  pc_sequencer #(
    .DATA_WIDTH   (32),
    .SIGNAL_WIDTH (3),
    .RAS_DEPTH    (DEPTH),
    .RESET_PC     (RPC),
    .PC_STEP      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] m_pc;
  logic        m_bt;
  logic        m_err;
  logic [31:0] m_stk [$];

  function automatic bit cond_ok(logic [2:0] c, bit z, bit n, bit v, bit cy);
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n != v;
      3'd3: return n == v;
      3'd4: return !cy;
      3'd5: return cy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_pc = RPC;
    m_bt = 1'b0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_step();
    logic [31:0] plus;
    logic [31:0] nxt;
    plus = m_pc + 32'd4;
    if (bus.stall) return;
    nxt = plus;
    m_bt = 1'b0;
    case (bus.pc_select)
      3'd1: if (cond_ok(bus.branch_cond, bus.zero, bus.negative,
                        bus.overflow, bus.carry)) begin
        nxt = bus.ext_sum;
        m_bt = 1'b1;
      end
      3'd2: begin nxt = bus.ext_signal; m_bt = 1'b1; end
      3'd3: begin nxt = bus.reg_bank_upper_data; m_bt = 1'b1; end
      3'd4: begin
        nxt = bus.ext_signal;
        m_bt = 1'b1;
        if (RAS) begin
          m_stk.push_back(plus);
          if (m_stk.size() > DEPTH) m_stk.delete(0);
        end
      end
      3'd5: begin
        if (!RAS) begin
          nxt = bus.reg_bank_upper_data;
          m_bt = 1'b1;
        end else if (m_stk.size() == 0) begin
          m_err = 1'b1;
        end else begin
          nxt = m_stk.pop_back();
          m_bt = 1'b1;
        end
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  function automatic logic [67:0] exp_v();
    logic e, f;
    e = RAS ? (m_stk.size() == 0) : 1'b1;
    f = RAS ? (m_stk.size() == DEPTH) : 1'b0;
    return {m_pc, m_pc + 32'd4, m_bt, e, f, m_err};
  endfunction

  function automatic logic [67:0] obs_v();
    return {bus.pc_out, bus.pc_plus, bus.branch_taken,
            bus.ras_empty, bus.ras_full, bus.ras_error};
  endfunction

  task automatic drive(logic [2:0] sel, logic [31:0] sig,
                       logic [31:0] rg, logic st);
    bus.pc_select = sel;
    bus.ext_signal = sig;
    bus.reg_bank_upper_data = rg;
    bus.stall = st;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(3'd2, 32'h1234, 32'h0, 1'b0);
    bus.branch_cond = 3'd0;
    {bus.zero, bus.negative, bus.overflow, bus.carry} = 4'b0;
    bus.ext_sum = 32'h0;
    m_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (obs_v() !== {RPC, RPC + 32'd4, 4'b0100}) begin
      bad++;
      $display("FAIL reset_async got %h want %h", obs_v(),
               {RPC, RPC + 32'd4, 4'b0100});
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.pc_out !== RPC) begin
      bad++;
      $display("FAIL reset_hold pc_out got %h want %h", bus.pc_out, RPC);
    end
    @(negedge clk);
    drive(3'd0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_seq();
    logic [31:0] want;
    for (int i = 1; i <= 3; i++) begin
      tick();
      want = RPC + 32'(4 * i);
      total++;
      if (bus.pc_out !== want || bus.branch_taken !== 1'b0) begin
        bad++;
        $display("FAIL seq%0d got pc=%h bt=%b want pc=%h bt=0",
                 i, bus.pc_out, bus.branch_taken, want);
      end
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      drive(3'd2, 32'h20, 32'h0, 1'b0);
      tick();
      drive(3'd1, 32'h0, 32'h0, 1'b0);
      bus.branch_cond = 3'd0;
      bus.zero = (k == 0);
      bus.ext_sum = 32'h80;
      tick();
      total++;
      if (bus.pc_out !== (k == 0 ? 32'h80 : 32'h24) ||
          bus.branch_taken !== (k == 0)) begin
        bad++;
        $display("FAIL branch_eq%0d got pc=%h bt=%b", k,
                 bus.pc_out, bus.branch_taken);
      end
    end
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f += 5) begin
        bus.pc_select = 3'd1;
        bus.branch_cond = 3'(c);
        {bus.zero, bus.negative, bus.overflow, bus.carry} = 4'(f);
        bus.ext_sum = $urandom & 32'hFFFFFFFC;
        tick();
        total++;
        if (obs_v() !== exp_v()) begin
          bad++;
          $display("FAIL branch_c%0d_f%0d got %h want %h", c, f,
                   obs_v(), exp_v());
        end
      end
    end
  endtask

  task automatic test_call_ret();
    drive(3'd2, 32'h40, 32'h0, 1'b0);
    tick();
    drive(3'd4, 32'h200, 32'h0, 1'b0);
    tick();
    total++;
    if (bus.pc_out !== 32'h200 || bus.branch_taken !== 1'b1) begin
      bad++;
      $display("FAIL call pc got %h want 200", bus.pc_out);
    end
    drive(3'd5, 32'h0, 32'h600, 1'b0);
    tick();
    total++;
    if (bus.pc_out !== (RAS ? 32'h44 : 32'h600) || bus.ras_empty !== 1'b1) begin
      bad++;
      $display("FAIL ret got pc=%h empty=%b want pc=%h empty=1",
               bus.pc_out, bus.ras_empty, RAS ? 32'h44 : 32'h600);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] want [5];
    want = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h28};
    for (int i = 1; i <= 5; i++) begin
      drive(3'd2, 32'(16 * i), 32'h0, 1'b0);
      tick();
      drive(3'd4, 32'h1000, 32'h0, 1'b0);
      tick();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL ovf_call%0d got %h want %h", i, obs_v(), exp_v());
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(3'd5, 32'h0, 32'h700, 1'b0);
      tick();
      total++;
      if (obs_v() !== exp_v() ||
          (RAS && (bus.pc_out !== want[i] ||
                   bus.ras_error !== (i == 4)))) begin
        bad++;
        $display("FAIL ovf_ret%0d got %h want %h", i, obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_stall();
    drive(3'd2, 32'h60, 32'h0, 1'b0);
    tick();
    drive(3'd4, 32'h300, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.pc_out !== 32'h60 || obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL stall%0d got %h want %h", i, obs_v(), exp_v());
      end
    end
    bus.stall = 1'b0;
    tick();
    total++;
    if (bus.pc_out !== 32'h300 || obs_v() !== exp_v()) begin
      bad++;
      $display("FAIL stall_call got %h want %h", obs_v(), exp_v());
    end
    drive(3'd5, 32'h0, 32'h800, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL stall_ret%0d got %h want %h", i, obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_wrap();
    drive(3'd2, 32'hFFFFFFFF, 32'h0, 1'b0);
    tick();
    total++;
    if (bus.pc_plus !== 32'h3) begin
      bad++;
      $display("FAIL wrap pc_plus got %h want 3", bus.pc_plus);
    end
    drive(3'd7, 32'h0, 32'h0, 1'b0);
    tick();
    total++;
    if (bus.pc_out !== 32'h3 || bus.branch_taken !== 1'b0) begin
      bad++;
      $display("FAIL wrap_seq pc got %h want 3", bus.pc_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.pc_select = 3'($urandom_range(0, 7));
      bus.branch_cond = 3'($urandom_range(0, 7));
      {bus.zero, bus.negative, bus.overflow, bus.carry} = 4'($urandom);
      bus.ext_sum = $urandom;
      bus.ext_signal = $urandom;
      bus.reg_bank_upper_data = $urandom;
      bus.stall = ($urandom_range(0, 3) == 0);
      tick();
      total++;
      if (obs_v() !== exp_v()) begin
        bad++;
        $display("FAIL rand%0d got %h want %h", i, obs_v(), exp_v());
      end
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(3'd2, 32'h80, 32'h0, 1'b0);
    tick();
    drive(3'd4, 32'h400, 32'h0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    total++;
    if (bus.pc_out !== RPC || bus.ras_empty !== 1'b1 ||
        bus.ras_error !== 1'b0 || bus.ras_full !== 1'b0 ||
        bus.branch_taken !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got %h want pc=%h empty=1 err=0",
               obs_v(), RPC);
    end
    @(negedge clk);
    drive(3'd5, 32'h0, 32'h900, 1'b0);
    rst_n = 1'b1;
    tick();
    total++;
    if (obs_v() !== exp_v()) begin
      bad++;
      $display("FAIL post_rst_ret got %h want %h", obs_v(), exp_v());
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_stall();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL use parameter DATA_WIDTH, default 32, as the width of the PC and all target buses.
REQ-002 The block SHALL use parameter SIGNAL_WIDTH, default 3, as the width of pc_select.
REQ-003 The block SHALL use parameter RAS_DEPTH, default 4, as the return-address stack entry count (power of two, >=2).
REQ-004 The block SHALL use parameter RESET_PC, default 32'h0, as the PC value after reset.
REQ-005 The block SHALL use parameter PC_STEP, default 4, as the sequential increment.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 stall  in  1  hold PC and stack this cycle.
REQ-009 pc_select  in  SIGNAL_WIDTH  000 seq, 001 branch, 010 jump, 011 jump-reg, 100 call, 101 return, others seq.
REQ-010 branch_cond  in  3  000 eq, 001 neq, 010 lt, 011 ge, 100 ltu, 101 geu, others never-taken.
REQ-011 zero, negative, overflow, carry  in  1 each  ALU flags of the compare.
REQ-012 ext_sum  in  DATA_WIDTH  branch target; ext_signal  in  DATA_WIDTH  jump/call target; reg_bank_upper_data  in  DATA_WIDTH  jump-reg target.
REQ-013 pc_out  out  DATA_WIDTH  registered PC; pc_plus  out  DATA_WIDTH  pc_out+PC_STEP, combinational.
REQ-014 branch_taken  out  1  registered, 1 when the last accepted update redirected the PC.
REQ-015 ras_empty, ras_full  out  1  combinational stack status; ras_error  out  1  sticky underflow flag.

Function
REQ-016 On each rising clk with stall=0, pc_out SHALL load next_pc; latency one cycle from inputs to pc_out.
REQ-017 With stall=1, pc_out, branch_taken, stack contents, pointer and ras_error SHALL hold.
REQ-018 next_pc: seq -> pc_plus; jump, call -> ext_signal; jump-reg -> reg_bank_upper_data; branch -> ext_sum if taken, else pc_plus.
REQ-019 Branch taken: eq=zero; neq=!zero; lt=negative^overflow; ge=!(negative^overflow); ltu=!carry; geu=carry.
REQ-020 pc_plus SHALL wrap modulo 2^DATA_WIDTH (all-ones PC plus 4 gives 3).
REQ-021 Call SHALL push pc_plus; when full, the oldest entry SHALL be overwritten, ras_full stays 1, no error.
REQ-022 Return SHALL pop and use the top entry as next_pc; when empty, next_pc SHALL be pc_plus and ras_error SHALL set.
REQ-023 branch_taken SHALL be 1 after jump, jump-reg, call, successful return or taken branch; 0 otherwise.
REQ-024 Undefined pc_select codes SHALL behave as seq with no stack activity.

Reset
REQ-025 rst_n low SHALL immediately force pc_out=RESET_PC, branch_taken=0, stack pointer=0 (ras_empty=1, ras_full=0), ras_error=0, regardless of stall.
REQ-026 Reset mid-call or mid-stall SHALL discard all stack contents; stack RAM contents need not be cleared.

Configuration
REQ-027 With macro PC_SEQUENCER_RAS_EN defined, the return-address stack SHALL be instantiated per REQ-021/022.
REQ-028 Without PC_SEQUENCER_RAS_EN, call SHALL act as jump, return SHALL act as jump-reg, and ras_empty=1, ras_full=0, ras_error=0 constantly.

Structure
REQ-029 Shared package pc_seq_pkg SHALL hold the pc_select and branch_cond encodings and the default RESET_PC/PC_STEP constants.
REQ-030 The stack SHALL be a sub-module return_stack (push, pop, data in/out, empty, full; circular pointer, saturating count).

Verification
REQ-031 Reset with RESET_PC=0x100, release, 3 seq cycles -> pc_out 0x100, 0x104, 0x108, 0x10C; branch_taken 0.
REQ-032 pc_out=0x20, branch, cond eq, zero=1, ext_sum=0x80 -> pc_out 0x80, branch_taken 1; same with zero=0 -> 0x24, branch_taken 0.
REQ-033 Call at 0x40 target 0x200, then return -> pc_out 0x200 then 0x44; ras_empty 1 afterward.
REQ-034 Five calls at depth 4 from 0x10,0x20,0x30,0x40,0x50, then five returns -> 0x54,0x44,0x34,0x24, then pc_plus with ras_error 1.
REQ-035 stall=1 for 3 cycles during call select -> pc_out and stack unchanged; first unstalled cycle performs the call once.
REQ-036 Assert rst_n low between clock edges after two calls -> pc_out=RESET_PC immediately, ras_empty 1, ras_error 0.
